// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - two-master AHB-Lite arbiter with address/data-phase ownership muxing
module ahb_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int DEFAULT_MASTER = 0,
    parameter int RR_MODE        = 0
) (
    input  logic          Hclk,
    input  logic          Hrst_n,
    input  logic          HBUSREQ_M0,
    input  logic          HBUSREQ_M1,
    input  logic [AW-1:0] HADDR_M0,
    input  logic [AW-1:0] HADDR_M1,
    input  logic [1:0]    HTRANS_M0,
    input  logic [1:0]    HTRANS_M1,
    input  logic          HWRITE_M0,
    input  logic          HWRITE_M1,
    input  logic [2:0]    HSIZE_M0,
    input  logic [2:0]    HSIZE_M1,
    input  logic [DW-1:0] HWDATA_M0,
    input  logic [DW-1:0] HWDATA_M1,
    input  logic          HREADY,
    output logic          HGRANT_M0,
    output logic          HGRANT_M1,
    output logic          HMASTER,
    output logic          HMASTER_D,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA
);

    typedef enum logic {
        OWN0 = 1'b0,
        OWN1 = 1'b1
    } own_t;

    localparam logic  DEF_M     = (DEFAULT_MASTER != 0);
    localparam logic  RR_EN     = (RR_MODE != 0);
    localparam own_t  DEF_STATE = DEF_M ? OWN1 : OWN0;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    own_t state, state_nxt;
    logic last_grant, last_grant_nxt;
    logic hmaster_q, hmaster_d_q;
    logic [1:0] owner_trans;
    logic rearb;
    logic winner;
    logic tie;

    always_ff @(posedge Hclk or negedge Hrst_n) begin
        if (!Hrst_n) begin
            state       <= DEF_STATE;
            last_grant  <= 1'b1;
            hmaster_q   <= DEF_M;
            hmaster_d_q <= DEF_M;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (HREADY) begin
                hmaster_q   <= (state == OWN1);
                hmaster_d_q <= hmaster_q;
            end
        end
    end

    // An owner mid-burst (SEQ/BUSY) keeps the bus; a stalled slave freezes arbitration.
    assign owner_trans = hmaster_q ? HTRANS_M1 : HTRANS_M0;
    assign rearb       = HREADY && (owner_trans != TR_SEQ) && (owner_trans != TR_BUSY);

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        winner         = (state == OWN1);
        tie            = 1'b0;
        if (rearb) begin
            case ({HBUSREQ_M1, HBUSREQ_M0})
                2'b00:   winner = DEF_M;
                2'b01:   winner = 1'b0;
                2'b10:   winner = 1'b1;
                default: begin
                    winner = RR_EN ? ~last_grant : 1'b0;
                    tie    = RR_EN;
                end
            endcase
            state_nxt = winner ? OWN1 : OWN0;
            // A resolved round-robin tie also advances the pointer so contenders alternate.
            if ((winner != (state == OWN1)) || tie)
                last_grant_nxt = winner;
        end
    end

    assign HGRANT_M0 = (state == OWN0);
    assign HGRANT_M1 = (state == OWN1);
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_d_q;

    assign HADDR  = hmaster_q   ? HADDR_M1  : HADDR_M0;
    assign HTRANS = hmaster_q   ? HTRANS_M1 : HTRANS_M0;
    assign HWRITE = hmaster_q   ? HWRITE_M1 : HWRITE_M0;
    assign HSIZE  = hmaster_q   ? HSIZE_M1  : HSIZE_M0;
    assign HWDATA = hmaster_d_q ? HWDATA_M1 : HWDATA_M0;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - scoreboard bench for ahb_bus_arbiter, fixed-priority and round-robin instances
module tb_ahb_bus_arbiter;

    localparam int S_G0 = 0, S_G1 = 1, S_HM = 2, S_HMD = 3, S_ADDR = 4,
                   S_WDATA = 5, S_TRANS = 6, S_WRITE = 7, S_SIZE = 8;

    logic        Hclk = 1'b0;
    logic        Hrst_n;
    logic        HBUSREQ_M0, HBUSREQ_M1;
    logic [31:0] HADDR_M0, HADDR_M1;
    logic [1:0]  HTRANS_M0, HTRANS_M1;
    logic        HWRITE_M0, HWRITE_M1;
    logic [2:0]  HSIZE_M0, HSIZE_M1;
    logic [31:0] HWDATA_M0, HWDATA_M1;
    logic        HREADY;

    logic [1:0]  g0, g1, hm, hmd, hwr;
    logic [31:0] haddr_fp, haddr_rr, hwdata_fp, hwdata_rr;
    logic [1:0]  htrans_fp, htrans_rr;
    logic [2:0]  hsize_fp, hsize_rr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          inst;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    always #5 Hclk = ~Hclk;

    ahb_bus_arbiter #(.AW(32), .DW(32), .DEFAULT_MASTER(0), .RR_MODE(0)) u_fp (
        .Hclk(Hclk), .Hrst_n(Hrst_n),
        .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1),
        .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
        .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
        .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
        .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
        .HREADY(HREADY),
        .HGRANT_M0(g0[0]), .HGRANT_M1(g1[0]), .HMASTER(hm[0]), .HMASTER_D(hmd[0]),
        .HADDR(haddr_fp), .HTRANS(htrans_fp), .HWRITE(hwr[0]), .HSIZE(hsize_fp),
        .HWDATA(hwdata_fp)
    );

    ahb_bus_arbiter #(.AW(32), .DW(32), .DEFAULT_MASTER(0), .RR_MODE(1)) u_rr (
        .Hclk(Hclk), .Hrst_n(Hrst_n),
        .HBUSREQ_M0(HBUSREQ_M0), .HBUSREQ_M1(HBUSREQ_M1),
        .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
        .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
        .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
        .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
        .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
        .HREADY(HREADY),
        .HGRANT_M0(g0[1]), .HGRANT_M1(g1[1]), .HMASTER(hm[1]), .HMASTER_D(hmd[1]),
        .HADDR(haddr_rr), .HTRANS(htrans_rr), .HWRITE(hwr[1]), .HSIZE(hsize_rr),
        .HWDATA(hwdata_rr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int inst, input int sel);
        case (sel)
            S_G0:    return {31'd0, g0[inst]};
            S_G1:    return {31'd0, g1[inst]};
            S_HM:    return {31'd0, hm[inst]};
            S_HMD:   return {31'd0, hmd[inst]};
            S_ADDR:  return inst == 0 ? haddr_fp : haddr_rr;
            S_WDATA: return inst == 0 ? hwdata_fp : hwdata_rr;
            S_TRANS: return {30'd0, (inst == 0 ? htrans_fp : htrans_rr)};
            S_WRITE: return {31'd0, hwr[inst]};
            default: return {29'd0, (inst == 0 ? hsize_fp : hsize_rr)};
        endcase
    endfunction

    task automatic push(input string tag, input int inst, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.inst = inst; e.sel = sel; e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_both(input string tag, input int sel, input logic [31:0] exp);
        push({tag, "_fp"}, 0, sel, exp);
        push({tag, "_rr"}, 1, sel, exp);
    endtask

    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, obs(e.inst, e.sel), e.exp);
        end
    endtask

    task automatic cycle();
        @(posedge Hclk);
        #1;
        drain();
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset(input string tag);
        #2;
        HBUSREQ_M0 = 0; HBUSREQ_M1 = 0;
        HADDR_M0 = 32'h0000_0999; HADDR_M1 = 32'h0000_0040;
        HTRANS_M0 = 2'b00; HTRANS_M1 = 2'b10;
        HWRITE_M0 = 0; HWRITE_M1 = 0;
        HSIZE_M0 = 3'd2; HSIZE_M1 = 3'd1;
        HWDATA_M0 = 32'h0; HWDATA_M1 = 32'h0;
        HREADY = 1;
        Hrst_n = 0;
        #1;
        push_both({tag, "_g0"}, S_G0, 1);
        push_both({tag, "_g1"}, S_G1, 0);
        push_both({tag, "_hm"}, S_HM, 0);
        push_both({tag, "_hmd"}, S_HMD, 0);
        push_both({tag, "_trans"}, S_TRANS, {30'd0, HTRANS_M0});
        drain();
        @(negedge Hclk);
        Hrst_n = 1;
    endtask

    initial begin
        Hrst_n = 0;
        HREADY = 1;
        repeat (2) @(posedge Hclk);
        #1;
        do_reset("rst0");

        // M1 alone: grant next edge, address owner the edge after
        HBUSREQ_M1 = 1;
        push_both("m1_g1", S_G1, 1); push_both("m1_hm_e1", S_HM, 0);
        cycle();
        push_both("m1_hm_e2", S_HM, 1); push_both("m1_addr", S_ADDR, 32'h40);
        push_both("m1_hmd_e2", S_HMD, 0);
        cycle();
        push_both("m1_hmd_e3", S_HMD, 1);
        cycle();

        // Both request: fixed priority holds M0, round-robin alternates
        do_reset("rst1");
        HBUSREQ_M0 = 1; HBUSREQ_M1 = 1;
        for (int i = 0; i < 4; i++) begin
            push("tie_fp_g0", 0, S_G0, 1);
            push("tie_rr_g1", 1, S_G1, (i % 2 == 1) ? 1 : 0);
            cycle();
        end

        // Write data of M0 follows its address while M1 takes the address phase
        do_reset("rst2");
        HBUSREQ_M1 = 1; HTRANS_M0 = 2'b10; HWRITE_M0 = 1; HADDR_M0 = 32'h100;
        push_both("wd_g1", S_G1, 1); push_both("wd_addr0", S_ADDR, 32'h100);
        push_both("wd_wr0", S_WRITE, 1);
        cycle();
        HWDATA_M0 = 32'hDEAD_BEEF; HWDATA_M1 = 32'h1111_1111;
        HADDR_M1 = 32'h200; HTRANS_M1 = 2'b10;
        push_both("wd_hm", S_HM, 1); push_both("wd_hmd", S_HMD, 0);
        push_both("wd_addr1", S_ADDR, 32'h200); push_both("wd_data0", S_WDATA, 32'hDEAD_BEEF);
        push_both("wd_wr1", S_WRITE, 0); push_both("wd_size1", S_SIZE, 3'd1);
        cycle();
        push_both("wd_data1", S_WDATA, 32'h1111_1111);
        cycle();

        // HREADY low freezes grants and the ownership pipeline
        do_reset("rst3");
        HBUSREQ_M1 = 1; HREADY = 0;
        for (int i = 0; i < 3; i++) begin
            push_both("st_g1", S_G1, 0); push_both("st_hm", S_HM, 0); push_both("st_hmd", S_HMD, 0);
            cycle();
        end
        HREADY = 1;
        push_both("st_sw_g1", S_G1, 1); push_both("st_sw_hm", S_HM, 0);
        cycle();
        HREADY = 0;
        for (int i = 0; i < 2; i++) begin
            push_both("st2_hm", S_HM, 0); push_both("st2_g1", S_G1, 1);
            cycle();
        end
        HREADY = 1;
        push_both("st3_hm", S_HM, 1); push_both("st3_hmd", S_HMD, 0);
        cycle();

        // Reset while M1 owns the bus
        do_reset("rst_mid");

        // SEQ/BUSY bursts hold the grant against a competing request
        HBUSREQ_M1 = 1; HTRANS_M1 = 2'b10;
        push_both("sq_g1", S_G1, 1);
        cycle();
        push_both("sq_hm", S_HM, 1);
        cycle();
        HBUSREQ_M0 = 1; HBUSREQ_M1 = 0;
        for (int i = 0; i < 3; i++) begin
            HTRANS_M1 = (i == 2) ? 2'b01 : 2'b11;
            push_both("sq_lock_g1", S_G1, 1); push_both("sq_trans", S_TRANS, {30'd0, HTRANS_M1});
            cycle();
        end
        HTRANS_M1 = 2'b00;
        push_both("sq_rel_g0", S_G0, 1); push_both("sq_rel_g1", S_G1, 0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
